controle_modos: RTL and testbench

- Central controller for the digital clock.
- Decodes the three front-panel buttons into mode selection, start/stop, and per-mode or global resets.
- Sequences the relogio, cronometro and timer datapaths through run enables and one-cycle reset pulses.
- Owns the timer-expiry alarm.
- Runs on the system clock. All time-based behaviour is counted in tick_1s strobes.

---
 rtl/controle_modos_if.sv | 47 ++++
 rtl/controle_modos.sv | 221 ++++++++++++++++++++++
 tb/tb_controle_modos.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/controle_modos_if.sv
// controle_modos_if
//   Bundle of the front-panel / datapath signals handled by the mode
//   controller of the digital clock.
//   master : the surroundings (buttons, 1 s tick, timer status); drives the
//            inputs of the controller and observes its outputs.
//   slave  : the controller itself.
//   Signals
//     tick_1s          one-clk strobe once per second
//     btn_modo         mode button level (synchronized/debounced)
//     btn_start        start/stop button level
//     btn_reset        reset button level
//     timer_zero       timer datapath count is 00:00
//     modo             0=RELOGIO 1=CRONOMETRO 2=TIMER 3=AJUSTE
//     ajuste_en        high while modo==3
//     cron_run         cronometro count enable
//     timer_run        timer countdown enable
//     reset_relogio    one-cycle reset pulse to relogio
//     reset_cronometro one-cycle reset pulse to cronometro
//     reset_timer      one-cycle reset pulse to timer
//     alarme           timer-expiry alarm
interface controle_modos_if;
  logic       tick_1s;
  logic       btn_modo;
  logic       btn_start;
  logic       btn_reset;
  logic       timer_zero;
  logic [1:0] modo;
  logic       ajuste_en;
  logic       cron_run;
  logic       timer_run;
  logic       reset_relogio;
  logic       reset_cronometro;
  logic       reset_timer;
  logic       alarme;

  modport master (
    output tick_1s, btn_modo, btn_start, btn_reset, timer_zero,
    input  modo, ajuste_en, cron_run, timer_run,
           reset_relogio, reset_cronometro, reset_timer, alarme
  );

  modport slave (
    input  tick_1s, btn_modo, btn_start, btn_reset, timer_zero,
    output modo, ajuste_en, cron_run, timer_run,
           reset_relogio, reset_cronometro, reset_timer, alarme
  );
endinterface

// File: rtl/controle_modos.sv
// controle_modos
//   Central controller of the digital clock. Decodes the three front-panel
//   buttons into mode selection, start/stop and per-mode / global resets,
//   drives the run enables and one-cycle reset pulses of the relogio,
//   cronometro and timer datapaths, and owns the timer-expiry alarm.
//   All time-based behaviour counts tick_1s strobes.
//   Ports
//     clk    system clock
//     reset  synchronous active-high reset, the only reset of the block
//     bus    controle_modos_if.slave (buttons, tick, timer_zero in;
//            modo, enables, reset pulses, alarme out)
//   Parameters
//     HOLD_SEC   ticks btn_reset must stay high for a long press (1..7)
//     ALARM_SEC  ticks alarme stays high after expiry (1..15)
module controle_modos #(
  parameter int unsigned HOLD_SEC  = 2,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic              clk,
  input  logic              reset,
  controle_modos_if.slave   bus
);

  localparam logic [1:0] M_RELOGIO    = 2'd0;
  localparam logic [1:0] M_CRONOMETRO = 2'd1;
  localparam logic [1:0] M_TIMER      = 2'd2;
  localparam logic [1:0] M_AJUSTE     = 2'd3;

  localparam logic [2:0] HOLD_MAX   = 3'(HOLD_SEC);
  localparam logic [3:0] ALARM_LOAD = 4'(ALARM_SEC);

  // Button index order in the vectors below.
  localparam int B_MODO  = 0;
  localparam int B_START = 1;
  localparam int B_RESET = 2;

  // ---------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------
  logic [2:0] btn;
  logic [2:0] prev_q, prev_d;
  logic [2:0] rise;
  logic       reset_fall;

  assign btn = {bus.btn_reset, bus.btn_start, bus.btn_modo};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      assign rise[gi] = btn[gi] & ~prev_q[gi];
    end
  endgenerate

  assign prev_d     = btn;
  assign reset_fall = prev_q[B_RESET] & ~btn[B_RESET];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0] modo_q, modo_d;
  logic       cron_run_q, cron_run_d;
  logic       timer_run_q, timer_run_d;
  logic       alarme_q, alarme_d;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic       long_flag_q, long_flag_d;
  logic       reset_relogio_q, reset_relogio_d;
  logic       reset_cronometro_q, reset_cronometro_d;
  logic       reset_timer_q, reset_timer_d;

  // ---------------------------------------------------------------------
  // Reset-button hold tracking
  // ---------------------------------------------------------------------
  logic long_evt;
  logic short_evt;
  logic expiry;

  // Long press fires once, on the first cycle the saturated count is seen;
  // the flag then blocks repeats and the short action on release.
  assign long_evt  = btn[B_RESET] && (hold_cnt_q == HOLD_MAX) && !long_flag_q;
  assign short_evt = reset_fall && (hold_cnt_q < HOLD_MAX) && !long_flag_q;
  assign expiry    = timer_run_q && bus.timer_zero;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!btn[B_RESET]) begin
      hold_cnt_d = 3'd0;
    end else if (bus.tick_1s && (hold_cnt_q < HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 3'd1;
    end
  end

  always_comb begin
    long_flag_d = long_flag_q;
    if (long_evt) begin
      long_flag_d = 1'b1;
    end else if (!btn[B_RESET]) begin
      long_flag_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q             <= 3'b000;
      modo_q             <= M_RELOGIO;
      cron_run_q         <= 1'b0;
      timer_run_q        <= 1'b0;
      alarme_q           <= 1'b0;
      alarm_cnt_q        <= 4'd0;
      hold_cnt_q         <= 3'd0;
      long_flag_q        <= 1'b0;
      reset_relogio_q    <= 1'b0;
      reset_cronometro_q <= 1'b0;
      reset_timer_q      <= 1'b0;
    end else begin
      prev_q             <= prev_d;
      modo_q             <= modo_d;
      cron_run_q         <= cron_run_d;
      timer_run_q        <= timer_run_d;
      alarme_q           <= alarme_d;
      alarm_cnt_q        <= alarm_cnt_d;
      hold_cnt_q         <= hold_cnt_d;
      long_flag_q        <= long_flag_d;
      reset_relogio_q    <= reset_relogio_d;
      reset_cronometro_q <= reset_cronometro_d;
      reset_timer_q      <= reset_timer_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. The if/else chain encodes the per-cycle priority:
  // long press > expiry > alarm-clear consumption > short reset >
  // mode / start (mode and start may act together).
  // ---------------------------------------------------------------------
  always_comb begin
    modo_d             = modo_q;
    cron_run_d         = cron_run_q;
    timer_run_d        = timer_run_q;
    alarme_d           = alarme_q;
    alarm_cnt_d        = alarm_cnt_q;
    reset_relogio_d    = 1'b0;
    reset_cronometro_d = 1'b0;
    reset_timer_d      = 1'b0;

    if (long_evt) begin
      reset_relogio_d    = 1'b1;
      reset_cronometro_d = 1'b1;
      reset_timer_d      = 1'b1;
      cron_run_d         = 1'b0;
      timer_run_d        = 1'b0;
      alarme_d           = 1'b0;
      alarm_cnt_d        = 4'd0;
      modo_d             = M_RELOGIO;
    end else if (expiry) begin
      timer_run_d = 1'b0;
      alarme_d    = 1'b1;
      alarm_cnt_d = ALARM_LOAD;
    end else if (alarme_q && (|rise)) begin
      // The press only silences the alarm.
      alarme_d    = 1'b0;
      alarm_cnt_d = 4'd0;
    end else begin
      if (alarme_q && bus.tick_1s) begin
        if (alarm_cnt_q <= 4'd1) begin
          alarme_d    = 1'b0;
          alarm_cnt_d = 4'd0;
        end else begin
          alarm_cnt_d = alarm_cnt_q - 4'd1;
        end
      end

      if (short_evt) begin
        case (modo_q)
          M_CRONOMETRO: begin
            reset_cronometro_d = 1'b1;
            cron_run_d         = 1'b0;
          end
          M_TIMER: begin
            reset_timer_d = 1'b1;
            timer_run_d   = 1'b0;
          end
          default: ;
        endcase
      end else begin
        if (rise[B_MODO]) begin
          modo_d = modo_q + 2'd1;
        end
        // Start acts on the mode held before any simultaneous mode change.
        if (rise[B_START]) begin
          case (modo_q)
            M_CRONOMETRO: cron_run_d = ~cron_run_q;
            M_TIMER: begin
              // A countdown cannot be started from 00:00.
              if (timer_run_q || !bus.timer_zero) begin
                timer_run_d = ~timer_run_q;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.modo             = modo_q;
    bus.ajuste_en        = (modo_q == M_AJUSTE);
    bus.cron_run         = cron_run_q;
    bus.timer_run        = timer_run_q;
    bus.reset_relogio    = reset_relogio_q;
    bus.reset_cronometro = reset_cronometro_q;
    bus.reset_timer      = reset_timer_q;
    bus.alarme           = alarme_q;
  end

endmodule

// File: tb/tb_controle_modos.sv
// tb_controle_modos
//   Directed bench for controle_modos: a per-cycle vector table for mode
//   cycling and start/stop, then hand-written sequences for timer expiry,
//   alarm consumption, short press and long press. Each step drives inputs,
//   waits one clock edge and compares all outputs 1 time unit later.
module tb_controle_modos;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  controle_modos_if bus ();

  controle_modos #(
    .HOLD_SEC (2),
    .ALARM_SEC(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs: {reset, tick_1s, btn_modo, btn_start, btn_reset, timer_zero}
  // expected: {modo[1:0], ajuste_en, cron_run, timer_run,
  //            reset_relogio, reset_cronometro, reset_timer, alarme}
  typedef struct packed {
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [32];

  function automatic logic [8:0] e(input logic [1:0] m, input logic aj,
                                   input logic cr, input logic tr,
                                   input logic rr, input logic rc,
                                   input logic rt, input logic al);
    return {m, aj, cr, tr, rr, rc, rt, al};
  endfunction

  task automatic step(input string name, input logic [5:0] in,
                      input logic [8:0] exp);
    logic [8:0] got;
    {reset, bus.tick_1s, bus.btn_modo, bus.btn_start, bus.btn_reset,
     bus.timer_zero} = in;
    @(posedge clk);
    #1;
    got = {bus.modo, bus.ajuste_en, bus.cron_run, bus.timer_run,
           bus.reset_relogio, bus.reset_cronometro, bus.reset_timer,
           bus.alarme};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (modo,aj,cr,tr,rr,rc,rt,al)",
               name, got, exp);
    end else begin
      $display("ok   %s: in=%b out=%b", name, in, got);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.tick_1s    = 1'b0;
    bus.btn_modo   = 1'b0;
    bus.btn_start  = 1'b0;
    bus.btn_reset  = 1'b0;
    bus.timer_zero = 1'b0;

    //                 rst tk bm bs br tz
    tbl[0]  = '{6'b100000, e(0,0,0,0,0,0,0,0)};  // reset state
    tbl[1]  = '{6'b101000, e(0,0,0,0,0,0,0,0)};  // modo held through reset
    tbl[2]  = '{6'b001000, e(1,0,0,0,0,0,0,0)};  // ...seen as a rise after
    tbl[3]  = '{6'b000000, e(1,0,0,0,0,0,0,0)};
    tbl[4]  = '{6'b001000, e(2,0,0,0,0,0,0,0)};
    tbl[5]  = '{6'b000000, e(2,0,0,0,0,0,0,0)};
    tbl[6]  = '{6'b001000, e(3,1,0,0,0,0,0,0)};
    tbl[7]  = '{6'b000000, e(3,1,0,0,0,0,0,0)};
    tbl[8]  = '{6'b001000, e(0,0,0,0,0,0,0,0)};  // wrap 3->0
    tbl[9]  = '{6'b000000, e(0,0,0,0,0,0,0,0)};
    tbl[10] = '{6'b001000, e(1,0,0,0,0,0,0,0)};
    tbl[11] = '{6'b000000, e(1,0,0,0,0,0,0,0)};
    tbl[12] = '{6'b000100, e(1,0,1,0,0,0,0,0)};  // cron start
    tbl[13] = '{6'b000000, e(1,0,1,0,0,0,0,0)};
    tbl[14] = '{6'b001000, e(2,0,1,0,0,0,0,0)};  // background counting
    tbl[15] = '{6'b000000, e(2,0,1,0,0,0,0,0)};
    tbl[16] = '{6'b001000, e(3,1,1,0,0,0,0,0)};
    tbl[17] = '{6'b000000, e(3,1,1,0,0,0,0,0)};
    tbl[18] = '{6'b001000, e(0,0,1,0,0,0,0,0)};
    tbl[19] = '{6'b000000, e(0,0,1,0,0,0,0,0)};
    tbl[20] = '{6'b001000, e(1,0,1,0,0,0,0,0)};
    tbl[21] = '{6'b000000, e(1,0,1,0,0,0,0,0)};
    tbl[22] = '{6'b000100, e(1,0,0,0,0,0,0,0)};  // cron stop
    tbl[23] = '{6'b000000, e(1,0,0,0,0,0,0,0)};
    tbl[24] = '{6'b001100, e(2,0,1,0,0,0,0,0)};  // modo+start: start on old modo
    tbl[25] = '{6'b000000, e(2,0,1,0,0,0,0,0)};
    tbl[26] = '{6'b000101, e(2,0,1,0,0,0,0,0)};  // start at 00:00 ignored
    tbl[27] = '{6'b000000, e(2,0,1,0,0,0,0,0)};
    tbl[28] = '{6'b000100, e(2,0,1,1,0,0,0,0)};  // timer start
    tbl[29] = '{6'b000000, e(2,0,1,1,0,0,0,0)};
    tbl[30] = '{6'b000100, e(2,0,1,0,0,0,0,0)};  // timer stop
    tbl[31] = '{6'b000000, e(2,0,1,0,0,0,0,0)};

    for (int i = 0; i < 32; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    // ---- expiry and alarm timeout (modo=2, cron_run=1) ----
    step("a_start",  6'b000100, e(2,0,1,1,0,0,0,0));
    step("a_rel",    6'b000000, e(2,0,1,1,0,0,0,0));
    step("a_expire", 6'b000001, e(2,0,1,0,0,0,0,1));
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("a_tick%0d", i), 6'b010001,
           e(2,0,1,0,0,0,0,(i < 10) ? 1'b1 : 1'b0));
      step($sformatf("a_idle%0d", i), 6'b000001,
           e(2,0,1,0,0,0,0,(i < 10) ? 1'b1 : 1'b0));
    end

    // ---- alarm cleared by btn_modo, modo unchanged ----
    step("b_start",  6'b000100, e(2,0,1,1,0,0,0,0));
    step("b_rel",    6'b000000, e(2,0,1,1,0,0,0,0));
    step("b_expire", 6'b000001, e(2,0,1,0,0,0,0,1));
    step("b_modo",   6'b001001, e(2,0,1,0,0,0,0,0));
    step("b_modo_r", 6'b000001, e(2,0,1,0,0,0,0,0));

    // ---- expiry beats a simultaneous start; later start only clears ----
    step("c_start",  6'b000100, e(2,0,1,1,0,0,0,0));
    step("c_rel",    6'b000000, e(2,0,1,1,0,0,0,0));
    step("c_exp_st", 6'b000101, e(2,0,1,0,0,0,0,1));
    step("c_hold",   6'b000001, e(2,0,1,0,0,0,0,1));
    step("c_st_rel", 6'b000000, e(2,0,1,0,0,0,0,1));
    step("c_consum", 6'b000100, e(2,0,1,0,0,0,0,0));
    step("c_rel2",   6'b000000, e(2,0,1,0,0,0,0,0));

    // ---- short press in CRONOMETRO ----
    step("d_m3",     6'b001000, e(3,1,1,0,0,0,0,0));
    step("d_m3r",    6'b000000, e(3,1,1,0,0,0,0,0));
    step("d_m0",     6'b001000, e(0,0,1,0,0,0,0,0));
    step("d_m0r",    6'b000000, e(0,0,1,0,0,0,0,0));
    step("d_m1",     6'b001000, e(1,0,1,0,0,0,0,0));
    step("d_m1r",    6'b000000, e(1,0,1,0,0,0,0,0));
    step("d_br",     6'b000010, e(1,0,1,0,0,0,0,0));
    step("d_brtick", 6'b010010, e(1,0,1,0,0,0,0,0));
    step("d_brhold", 6'b000010, e(1,0,1,0,0,0,0,0));
    step("d_brfall", 6'b000000, e(1,0,0,0,0,1,0,0));
    step("d_after",  6'b000000, e(1,0,0,0,0,0,0,0));

    // ---- long press from TIMER with both runs active ----
    step("e_cst",    6'b000100, e(1,0,1,0,0,0,0,0));
    step("e_cstr",   6'b000000, e(1,0,1,0,0,0,0,0));
    step("e_m2",     6'b001000, e(2,0,1,0,0,0,0,0));
    step("e_m2r",    6'b000000, e(2,0,1,0,0,0,0,0));
    step("e_tst",    6'b000100, e(2,0,1,1,0,0,0,0));
    step("e_tstr",   6'b000000, e(2,0,1,1,0,0,0,0));
    step("e_br",     6'b000010, e(2,0,1,1,0,0,0,0));
    step("e_tick1",  6'b010010, e(2,0,1,1,0,0,0,0));
    step("e_hold1",  6'b000010, e(2,0,1,1,0,0,0,0));
    step("e_tick2",  6'b010010, e(2,0,1,1,0,0,0,0));
    step("e_long",   6'b000010, e(0,0,0,0,1,1,1,0));
    step("e_pulse1", 6'b000010, e(0,0,0,0,0,0,0,0));
    for (int i = 1; i <= 3; i++) begin
      step($sformatf("e_xtick%0d", i), 6'b010010, e(0,0,0,0,0,0,0,0));
      step($sformatf("e_xhold%0d", i), 6'b000010, e(0,0,0,0,0,0,0,0));
    end
    // move to CRONOMETRO while still holding so the release would matter
    step("e_m1",     6'b001010, e(1,0,0,0,0,0,0,0));
    step("e_m1r",    6'b000010, e(1,0,0,0,0,0,0,0));
    step("e_relse",  6'b000000, e(1,0,0,0,0,0,0,0));
    step("e_idle",   6'b000000, e(1,0,0,0,0,0,0,0));
    // flag cleared: a fresh short press acts again
    step("f_br",     6'b000010, e(1,0,0,0,0,0,0,0));
    step("f_fall",   6'b000000, e(1,0,0,0,0,1,0,0));
    step("f_after",  6'b000000, e(1,0,0,0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
